// File: rtl/fifo_w16_r8.sv
// fifo_w16_r8: single-clock FIFO, 16-bit write port, 8-bit read port, MSB byte returned first.
// Define FIFO_PROG_FLAGS_EN to build the prog_full/prog_empty threshold comparators.
`timescale 1ns/1ps
module fifo_w16_r8 #(
    parameter int unsigned WR_DEPTH          = 256,
    parameter int unsigned PROG_FULL_THRESH  = 200,
    parameter int unsigned PROG_EMPTY_THRESH = 8
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic [15:0]                   din,
    input  logic                          wr_en,
    input  logic                          rd_en,
    output logic [7:0]                    dout,
    output logic                          full,
    output logic                          almost_full,
    output logic                          wr_ack,
    output logic                          overflow,
    output logic                          empty,
    output logic                          almost_empty,
    output logic                          valid,
    output logic                          underflow,
    output logic [$clog2(2*WR_DEPTH):0]   rd_data_count,
    output logic [$clog2(WR_DEPTH):0]     wr_data_count,
    output logic                          prog_full,
    output logic                          prog_empty
);

    localparam int unsigned BYTE_DEPTH = 2 * WR_DEPTH;
    localparam int unsigned AW         = $clog2(BYTE_DEPTH);
    localparam int unsigned CW         = AW + 1;
    localparam int unsigned WCW        = CW - 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(BYTE_DEPTH - 2);

    // Elaboration-time guard on parameter legality
    if ((WR_DEPTH < 2) || ((WR_DEPTH & (WR_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fifo_w16_r8: WR_DEPTH must be a power of 2");
    end
    if ((PROG_FULL_THRESH > WR_DEPTH) || (PROG_EMPTY_THRESH > BYTE_DEPTH)) begin : g_bad_thresh
        $error("fifo_w16_r8: programmable threshold outside occupancy range");
    end

    logic [7:0]    mem [BYTE_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] byte_count;
    logic [CW-1:0] count_nxt;
    logic          wr_acc_c;
    logic          rd_acc_c;

    // Requests are judged against the flags as they stand before the edge
    assign wr_acc_c = wr_en && !full;
    assign rd_acc_c = rd_en && !empty;

    // Status decode from the registered occupancy
    assign full          = byte_count > FULL_LVL;
    assign almost_full   = byte_count >= FULL_LVL;
    assign empty         = byte_count == '0;
    assign almost_empty  = byte_count <= CW'(1);
    assign rd_data_count = byte_count;
    assign wr_data_count = byte_count[CW-1:1];

`ifdef FIFO_PROG_FLAGS_EN
    assign prog_full  = wr_data_count >= WCW'(PROG_FULL_THRESH);
    assign prog_empty = rd_data_count <= CW'(PROG_EMPTY_THRESH);
`else
    assign prog_full  = 1'b0;
    assign prog_empty = 1'b1;
`endif

    // Occupancy update: a word in is two bytes, a read removes one
    always_comb begin
        count_nxt = byte_count;
        unique case ({wr_acc_c, rd_acc_c})
            2'b10:   count_nxt = byte_count + CW'(2);
            2'b01:   count_nxt = byte_count - CW'(1);
            2'b11:   count_nxt = byte_count + CW'(1);
            default: count_nxt = byte_count;
        endcase
    end

    // Byte storage; wptr is always even so its odd partner is wptr with bit 0 set
    always_ff @(posedge Clk) begin
        if (wr_acc_c) begin
            mem[wptr]                <= din[15:8];
            mem[{wptr[AW-1:1], 1'b1}] <= din[7:0];
        end
    end

    // Pointers, occupancy, read data and handshake flags
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wptr       <= '0;
            rptr       <= '0;
            byte_count <= '0;
            dout       <= 8'h00;
            wr_ack     <= 1'b0;
            overflow   <= 1'b0;
            valid      <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            byte_count <= count_nxt;
            if (wr_acc_c) begin
                wptr <= wptr + AW'(2);
            end
            if (rd_acc_c) begin
                rptr <= rptr + AW'(1);
                dout <= mem[rptr];
            end
            wr_ack    <= wr_acc_c;
            overflow  <= wr_en && full;
            valid     <= rd_acc_c;
            underflow <= rd_en && empty;
        end
    end

endmodule

// File: tb/tb_fifo_w16_r8.sv
// tb_fifo_w16_r8: scoreboard bench for the 16-in / 8-out FIFO.
`timescale 1ns/1ps
module tb_fifo_w16_r8;

    localparam int BD = 512;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [15:0] din;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  dout;
    logic        full, almost_full, wr_ack, overflow;
    logic        empty, almost_empty, valid, underflow;
    logic [9:0]  rd_data_count;
    logic [8:0]  wr_data_count;
    logic        prog_full, prog_empty;

    int         checks = 0;
    int         failures = 0;
    int         mcount = 0;
    logic [7:0] sb [$];
    logic [7:0] last_byte = 8'h00;
    logic       e_wr_ack, e_ovf, e_valid, e_udf;

    fifo_w16_r8 dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .din           (din),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .dout          (dout),
        .full          (full),
        .almost_full   (almost_full),
        .wr_ack        (wr_ack),
        .overflow      (overflow),
        .empty         (empty),
        .almost_empty  (almost_empty),
        .valid         (valid),
        .underflow     (underflow),
        .rd_data_count (rd_data_count),
        .wr_data_count (wr_data_count),
        .prog_full     (prog_full),
        .prog_empty    (prog_empty)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Expected {full, almost_full, empty, almost_empty, prog_full, prog_empty} for a byte count
    function automatic logic [5:0] exp_flags(input int c);
        logic pf, pe;
`ifdef FIFO_PROG_FLAGS_EN
        pf = (c / 2) >= 200;
        pe = c <= 8;
`else
        pf = 1'b0;
        pe = 1'b1;
`endif
        return {c > BD - 2, c >= BD - 2, c == 0, c <= 1, pf, pe};
    endfunction

    // One clock: drive requests, advance the model, sample 1 ns after the edge
    task automatic cyc(input logic we, input logic [15:0] d, input logic re);
        logic wacc, racc;
        wr_en = we;
        din   = d;
        rd_en = re;
        wacc  = we && (mcount <= BD - 2);
        racc  = re && (mcount != 0);
        if (wacc) begin
            sb.push_back(d[15:8]);
            sb.push_back(d[7:0]);
        end
        e_wr_ack = wacc;
        e_ovf    = we && !wacc;
        e_valid  = racc;
        e_udf    = re && !racc;
        mcount   = mcount + (wacc ? 2 : 0) - (racc ? 1 : 0);
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        wr_en = 1'b1; rd_en = 1'b1; din = 16'hFFFF;
        #200;
        checks++;
        if ({full, almost_full, empty, almost_empty, prog_full, prog_empty} !== exp_flags(0)) begin
            failures++;
            $display("FAIL reset_flags: got %b expected %b",
                     {full, almost_full, empty, almost_empty, prog_full, prog_empty}, exp_flags(0));
        end
        checks++;
        if (rd_data_count !== 10'd0 || wr_data_count !== 9'd0) begin
            failures++;
            $display("FAIL reset_counts: got rd=%0d wr=%0d expected 0/0", rd_data_count, wr_data_count);
        end
        checks++;
        if (dout !== 8'h00) begin
            failures++;
            $display("FAIL reset_dout: got %h expected 00", dout);
        end
        checks++;
        if ({wr_ack, overflow, valid, underflow} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_handshake: got %b expected 0000", {wr_ack, overflow, valid, underflow});
        end
        wr_en = 1'b0; rd_en = 1'b0; din = 16'h0000;
        Reset_n = 1'b1;
        mcount = 0;
        sb.delete();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 250; i++) begin
            cyc(1'b1, 16'(i), 1'b0);
            checks++;
            if (wr_ack !== 1'b1 || overflow !== 1'b0) begin
                failures++;
                $display("FAIL fill_ack[%0d]: got ack=%b ovf=%b expected 1/0", i, wr_ack, overflow);
            end
            checks++;
            if (rd_data_count !== 10'(mcount) || wr_data_count !== 9'(mcount / 2)) begin
                failures++;
                $display("FAIL fill_count[%0d]: got rd=%0d wr=%0d expected %0d/%0d",
                         i, rd_data_count, wr_data_count, mcount, mcount / 2);
            end
            checks++;
            if ({full, almost_full, empty, almost_empty, prog_full, prog_empty} !== exp_flags(mcount)) begin
                failures++;
                $display("FAIL fill_flags[%0d]: got %b expected %b", i,
                         {full, almost_full, empty, almost_empty, prog_full, prog_empty}, exp_flags(mcount));
            end
        end
        checks++;
        if (wr_data_count !== 9'd250 || rd_data_count !== 10'd500) begin
            failures++;
            $display("FAIL fill_total: got wr=%0d rd=%0d expected 250/500", wr_data_count, rd_data_count);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        for (int i = 251; i <= 262; i++) begin
            cyc(1'b1, 16'(i), 1'b0);
            checks++;
            if (wr_ack !== e_wr_ack || overflow !== e_ovf) begin
                failures++;
                $display("FAIL ovf_hs[%0d]: got ack=%b ovf=%b expected %b/%b",
                         i, wr_ack, overflow, e_wr_ack, e_ovf);
            end
            checks++;
            if (rd_data_count !== 10'(mcount) ||
                {full, almost_full, empty, almost_empty, prog_full, prog_empty} !== exp_flags(mcount)) begin
                failures++;
                $display("FAIL ovf_state[%0d]: got rd=%0d flags=%b expected %0d/%b", i, rd_data_count,
                         {full, almost_full, empty, almost_empty, prog_full, prog_empty},
                         mcount, exp_flags(mcount));
            end
        end
        checks++;
        if (rd_data_count !== 10'd512 || wr_data_count !== 9'd256) begin
            failures++;
            $display("FAIL ovf_total: got rd=%0d wr=%0d expected 512/256", rd_data_count, wr_data_count);
        end
        // Write while full overflows even though the read in the same cycle succeeds
        cyc(1'b1, 16'h0200, 1'b1);
        exp = sb.pop_front();
        last_byte = exp;
        checks++;
        if (overflow !== 1'b1 || wr_ack !== 1'b0 || valid !== 1'b1 || dout !== exp) begin
            failures++;
            $display("FAIL full_wr_rd: got ovf=%b ack=%b valid=%b dout=%h expected 1/0/1/%h",
                     overflow, wr_ack, valid, dout, exp);
        end
        cyc(1'b1, 16'h0300, 1'b0);
        checks++;
        if (overflow !== 1'b1 || rd_data_count !== 10'd511 || full !== 1'b1) begin
            failures++;
            $display("FAIL full_511: got ovf=%b rd=%0d full=%b expected 1/511/1",
                     overflow, rd_data_count, full);
        end
    endtask

    task automatic test_drain();
        logic [7:0] exp;
        for (int i = 0; i < 520 && mcount > 0; i++) begin
            cyc(1'b0, 16'h0000, 1'b1);
            exp = sb.pop_front();
            last_byte = exp;
            checks++;
            if (valid !== 1'b1 || dout !== exp) begin
                failures++;
                $display("FAIL drain_data[%0d]: got valid=%b dout=%h expected 1/%h", i, valid, dout, exp);
            end
            checks++;
            if (rd_data_count !== 10'(mcount) ||
                {full, almost_full, empty, almost_empty, prog_full, prog_empty} !== exp_flags(mcount)) begin
                failures++;
                $display("FAIL drain_state[%0d]: got rd=%0d flags=%b expected %0d/%b", i, rd_data_count,
                         {full, almost_full, empty, almost_empty, prog_full, prog_empty},
                         mcount, exp_flags(mcount));
            end
        end
        cyc(1'b0, 16'h0000, 1'b1);
        checks++;
        if (underflow !== 1'b1 || valid !== 1'b0 || dout !== last_byte) begin
            failures++;
            $display("FAIL drain_underflow: got udf=%b valid=%b dout=%h expected 1/0/%h",
                     underflow, valid, dout, last_byte);
        end
        cyc(1'b0, 16'h0000, 1'b0);
        checks++;
        if (underflow !== 1'b0 || dout !== last_byte) begin
            failures++;
            $display("FAIL idle_hold: got udf=%b dout=%h expected 0/%h", underflow, dout, last_byte);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp;
        // Write while empty: read underflows, write lands
        cyc(1'b1, 16'hBEEF, 1'b1);
        checks++;
        if (underflow !== 1'b1 || wr_ack !== 1'b1 || valid !== 1'b0 || rd_data_count !== 10'd2) begin
            failures++;
            $display("FAIL empty_wr_rd: got udf=%b ack=%b valid=%b rd=%0d expected 1/1/0/2",
                     underflow, wr_ack, valid, rd_data_count);
        end
        cyc(1'b1, 16'hA1B2, 1'b0);
        cyc(1'b0, 16'h0000, 1'b1);
        exp = sb.pop_front();
        checks++;
        if (dout !== exp || rd_data_count !== 10'd3) begin
            failures++;
            $display("FAIL sim_setup: got dout=%h rd=%0d expected %h/3", dout, rd_data_count, exp);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 16'h1100 + 16'(i), 1'b1);
            exp = sb.pop_front();
            checks++;
            if (rd_data_count !== 10'(4 + i) || valid !== 1'b1 || dout !== exp) begin
                failures++;
                $display("FAIL sim[%0d]: got rd=%0d valid=%b dout=%h expected %0d/1/%h",
                         i, rd_data_count, valid, dout, 4 + i, exp);
            end
            checks++;
            if (wr_ack !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0 ||
                {full, almost_full, empty, almost_empty, prog_full, prog_empty} !== exp_flags(mcount)) begin
                failures++;
                $display("FAIL sim_flags[%0d]: got ack=%b ovf=%b udf=%b flags=%b expected 1/0/0/%b", i,
                         wr_ack, overflow, underflow,
                         {full, almost_full, empty, almost_empty, prog_full, prog_empty}, exp_flags(mcount));
            end
        end
        for (int i = 0; i < 20 && mcount > 0; i++) begin
            cyc(1'b0, 16'h0000, 1'b1);
            exp = sb.pop_front();
            checks++;
            if (valid !== 1'b1 || dout !== exp) begin
                failures++;
                $display("FAIL sim_drain[%0d]: got valid=%b dout=%h expected 1/%h", i, valid, dout, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 100; i++) begin
            cyc(1'b1, 16'h5A00 + 16'(i), 1'b0);
        end
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if (empty !== 1'b1 || rd_data_count !== 10'd0 || wr_data_count !== 9'd0 || wr_ack !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: got empty=%b rd=%0d wr=%0d ack=%b expected 1/0/0/0",
                     empty, rd_data_count, wr_data_count, wr_ack);
        end
        mcount = 0;
        sb.delete();
        @(posedge Clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
        Reset_n = 1'b1;
        cyc(1'b0, 16'h0000, 1'b1);
        checks++;
        if (underflow !== 1'b1 || valid !== 1'b0 || dout !== 8'h00) begin
            failures++;
            $display("FAIL post_reset_read: got udf=%b valid=%b dout=%h expected 1/0/00",
                     underflow, valid, dout);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
